// File: rtl/traffic_pkg.sv
// Shared encodings for the N-phase traffic sequencer: FSM states and lamp drive codes.
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_ALL_RED = 2'd0,
        ST_GREEN   = 2'd1,
        ST_YELLOW  = 2'd2,
        ST_FLASH   = 2'd3
    } state_t;

    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_DARK   = 3'b000;

endpackage

// File: rtl/traffic_rr_select.sv
// Rotating find-first: returns the first phase at or after ptr with demand set,
// or ptr itself when nothing is requested.
module traffic_rr_select #(
    parameter int NUM_PHASES = 4
) (
    input  logic [NUM_PHASES-1:0]         demand,
    input  logic [$clog2(NUM_PHASES)-1:0] ptr,
    output logic [$clog2(NUM_PHASES)-1:0] sel
);
    localparam int IDX_W = $clog2(NUM_PHASES);

    logic [IDX_W-1:0] cand;

    // Walk from the farthest offset down so the closest requesting phase wins.
    always_comb begin
        sel  = ptr;
        cand = '0;
        for (int k = NUM_PHASES - 1; k >= 0; k--) begin
            if (int'(ptr) + k >= NUM_PHASES) begin
                cand = IDX_W'(int'(ptr) + k - NUM_PHASES);
            end else begin
                cand = IDX_W'(int'(ptr) + k);
            end
            if (demand[cand]) begin
                sel = cand;
            end
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-phase GREEN/YELLOW/ALL_RED sequencer with demand-driven phase skipping.
// Optional flashing-yellow mode is built when TRAFFIC_FLASH_EN is defined.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_ALL_RED | clearance, every lamp red; next phase picked on last cycle
// ST_GREEN   | served phase green for its latched green time
// ST_YELLOW  | served phase yellow; ptr advances on exit
// ST_FLASH   | all lamps blink yellow/dark while flash is held
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_PHASES  = 4,
    parameter int CNT_W       = 8,
    parameter int YELLOW_CYC  = 2,
    parameter int ALL_RED_CYC = 1,
    parameter int FLASH_CYC   = 3
) (
    input  logic                          clk,
    input  logic                          rst,
`ifdef TRAFFIC_FLASH_EN
    input  logic                          flash,
`endif
    input  logic [NUM_PHASES*CNT_W-1:0]   green_time,
    input  logic [NUM_PHASES-1:0]         demand,
    output logic [NUM_PHASES*3-1:0]       light,
    output logic [$clog2(NUM_PHASES)-1:0] phase_idx,
    output logic [1:0]                    state_o,
    output logic [CNT_W-1:0]              count,
    output logic                          phase_start
);
    localparam int               IDX_W    = $clog2(NUM_PHASES);
    localparam logic [CNT_W-1:0] YEL_LIM  = CNT_W'(YELLOW_CYC);
    localparam logic [CNT_W-1:0] AR_LIM   = CNT_W'(ALL_RED_CYC);
    localparam logic [CNT_W-1:0] FL_LIM   = CNT_W'(FLASH_CYC);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PHASES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] count_nxt, green_lim, green_lim_nxt;
    logic [IDX_W-1:0] phase_nxt, ptr, ptr_nxt, sel;
    logic             pstart_nxt, flash_dark, flash_dark_nxt, flash_req;

`ifdef TRAFFIC_FLASH_EN
    assign flash_req = flash;
`else
    assign flash_req = 1'b0;
`endif

    traffic_rr_select #(.NUM_PHASES(NUM_PHASES)) u_rr_select (
        .demand (demand),
        .ptr    (ptr),
        .sel    (sel)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_ALL_RED;
            count       <= '0;
            phase_idx   <= '0;
            ptr         <= '0;
            green_lim   <= '0;
            phase_start <= 1'b0;
            flash_dark  <= 1'b0;
        end else begin
            state       <= state_nxt;
            count       <= count_nxt;
            phase_idx   <= phase_nxt;
            ptr         <= ptr_nxt;
            green_lim   <= green_lim_nxt;
            phase_start <= pstart_nxt;
            flash_dark  <= flash_dark_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        count_nxt      = count;
        phase_nxt      = phase_idx;
        ptr_nxt        = ptr;
        green_lim_nxt  = green_lim;
        pstart_nxt     = 1'b0;
        flash_dark_nxt = flash_dark;
        if (flash_req && state != ST_FLASH) begin
            state_nxt      = ST_FLASH;
            count_nxt      = '0;
            flash_dark_nxt = 1'b0;
        end else begin
            case (state)
                ST_ALL_RED: begin
                    if (count < AR_LIM) begin
                        count_nxt = count + CNT_W'(1);
                    end else begin
                        count_nxt     = '0;
                        state_nxt     = ST_GREEN;
                        phase_nxt     = sel;
                        green_lim_nxt = green_time[int'(sel)*CNT_W +: CNT_W];
                        pstart_nxt    = 1'b1;
                    end
                end
                ST_GREEN: begin
                    if (count < green_lim) begin
                        count_nxt = count + CNT_W'(1);
                    end else begin
                        count_nxt = '0;
                        state_nxt = ST_YELLOW;
                    end
                end
                ST_YELLOW: begin
                    if (count < YEL_LIM) begin
                        count_nxt = count + CNT_W'(1);
                    end else begin
                        count_nxt = '0;
                        state_nxt = ST_ALL_RED;
                        ptr_nxt   = (phase_idx == LAST_IDX) ? '0 : phase_idx + IDX_W'(1);
                    end
                end
                ST_FLASH: begin
                    // Without a live request (or without the feature) this falls back to clearance.
                    if (!flash_req) begin
                        state_nxt      = ST_ALL_RED;
                        count_nxt      = '0;
                        flash_dark_nxt = 1'b0;
                    end else if (count < FL_LIM) begin
                        count_nxt = count + CNT_W'(1);
                    end else begin
                        count_nxt      = '0;
                        flash_dark_nxt = ~flash_dark;
                    end
                end
                default: begin
                    state_nxt = ST_ALL_RED;
                    count_nxt = '0;
                end
            endcase
        end
    end

    assign state_o = state;

    always_comb begin
        light = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            light[i*3 +: 3] = LAMP_RED;
            if (state == ST_FLASH) begin
                light[i*3 +: 3] = flash_dark ? LAMP_DARK : LAMP_YELLOW;
            end else if (phase_idx == IDX_W'(i)) begin
                case (state)
                    ST_GREEN:  light[i*3 +: 3] = LAMP_GREEN;
                    ST_YELLOW: light[i*3 +: 3] = LAMP_YELLOW;
                    default:   light[i*3 +: 3] = LAMP_RED;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench for traffic_phase_ctrl: expected greens are queued per test,
// a negedge monitor checks each phase_start against the queue.
module tb_traffic_phase_ctrl;
    localparam int NP = 4;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NP*CW-1:0] green_time;
    logic [NP-1:0]   demand;
    logic [NP*3-1:0] light;
    logic [1:0]      phase_idx;
    logic [1:0]      state_o;
    logic [CW-1:0]   count;
    logic            phase_start;
`ifdef TRAFFIC_FLASH_EN
    logic            flash = 1'b0;
`endif

    traffic_phase_ctrl #(
        .NUM_PHASES(NP), .CNT_W(CW), .YELLOW_CYC(2), .ALL_RED_CYC(1), .FLASH_CYC(3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef TRAFFIC_FLASH_EN
        .flash       (flash),
`endif
        .green_time  (green_time),
        .demand      (demand),
        .light       (light),
        .phase_idx   (phase_idx),
        .state_o     (state_o),
        .count       (count),
        .phase_start (phase_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int cyc;
        int glen;   // 0: green is interrupted, length not checked
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   cur_active = 0;
    int   gcnt = 0;
    int   cyc;
    int   total = 0;
    int   bad = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic int lamp_word(int idx);
        logic [NP*3-1:0] w;
        for (int i = 0; i < NP; i++) w[i*3 +: 3] = (i == idx) ? 3'b001 : 3'b100;
        return int'(w);
    endfunction

    task automatic chk(string name, int act, int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic push(int idx, int c, int glen);
        exp_t e;
        e.idx = idx; e.cyc = c; e.glen = glen;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            cur_active = 0;
        end else begin
            if (phase_start) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_start: got phase %0d at cycle %0d, expected none", phase_idx, cyc);
                end else begin
                    cur = q.pop_front();
                    chk("start_idx",   int'(phase_idx), cur.idx);
                    chk("start_cyc",   cyc,             cur.cyc);
                    chk("start_light", int'(light),     lamp_word(cur.idx));
                    chk("start_state", int'(state_o),   1);
                    chk("start_count", int'(count),     0);
                    cur_active = 1;
                    gcnt = 0;
                end
            end
            if (cur_active) begin
                if (state_o == 2'd1) begin
                    gcnt++;
                end else begin
                    if (state_o == 2'd2 && cur.glen != 0) chk("green_len", gcnt, cur.glen);
                    cur_active = 0;
                end
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(string name);
        int n = 0;
        while ((q.size() != 0 || cur_active) && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, int'(q.size() == 0 && !cur_active), 1);
    endtask

    task automatic wait_cyc(int c);
        int n = 0;
        while (cyc != c && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("wait_cyc", cyc, c);
    endtask

    initial begin
        green_time = {4'd3, 4'd3, 4'd3, 4'd3};
        demand     = 4'b1111;
        rst        = 1'b1;
        #1;
        chk("rst_state", int'(state_o), 0);
        chk("rst_phase", int'(phase_idx), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_pstart", int'(phase_start), 0);
        chk("rst_light", int'(light), 'h924);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // full demand: plain rotation 0..3
        push(0, 2, 4); push(1, 11, 4); push(2, 20, 4); push(3, 29, 4);
        @(negedge clk);
        #1;
        chk("ar1_state", int'(state_o), 0);
        chk("ar1_count", int'(count), 1);
        drain("t_full_demand");

        // only phase 3 requests
        demand = 4'b1000;
        apply_reset();
        push(3, 2, 4); push(3, 11, 4); push(3, 20, 4);
        drain("t_only_p3");

        // no demand, distinct green times, mid-green change of phase 1 time ignored
        demand     = 4'b0000;
        green_time = {4'd2, 4'd1, 4'd5, 4'd3};
        apply_reset();
        push(0, 2, 4); push(1, 11, 6); push(2, 22, 2); push(3, 29, 3); push(0, 37, 4);
        wait_cyc(13);
        green_time[7:4] = 4'd1;
        drain("t_rotation");

        // zero green time gives a single green cycle
        demand     = 4'b0010;
        green_time = {4'd3, 4'd3, 4'd0, 4'd3};
        apply_reset();
        push(1, 2, 1); push(1, 8, 1); push(1, 14, 1);
        drain("t_zero_green");

        // sparse demand with pointer wrap
        demand     = 4'b0101;
        green_time = {4'd3, 4'd3, 4'd3, 4'd3};
        apply_reset();
        push(0, 2, 4); push(2, 11, 4); push(0, 20, 4); push(2, 29, 4);
        drain("t_skip_wrap");

        // asynchronous reset in the middle of phase 2 green
        demand = 4'b0000;
        apply_reset();
        push(0, 2, 4); push(1, 11, 4); push(2, 20, 0);
        wait_cyc(22);
        chk("pre_rst_phase", int'(phase_idx), 2);
        chk("pre_rst_state", int'(state_o), 1);
        rst = 1'b1;
        #1;
        chk("async_rst_light", int'(light), 'h924);
        chk("async_rst_phase", int'(phase_idx), 0);
        chk("async_rst_count", int'(count), 0);
        chk("async_rst_state", int'(state_o), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        push(0, 2, 4);
        drain("t_mid_reset");

`ifdef TRAFFIC_FLASH_EN
        demand = 4'b1111;
        apply_reset();
        push(0, 2, 4); push(1, 11, 0);
        wait_cyc(12);
        flash = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            chk("flash_light", int'(light), ((i / 4) % 2 == 1) ? 0 : 'h492);
            chk("flash_state", int'(state_o), 3);
            chk("flash_pstart", int'(phase_start), 0);
        end
        flash = 1'b0;
        push(1, 27, 4);
        @(negedge clk);
        #1;
        chk("flash_exit_state", int'(state_o), 0);
        chk("flash_exit_count", int'(count), 0);
        drain("t_flash");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
Parametrised N-phase traffic-signal sequencer. It is the successor to the fixed six-state, four-light intersection controller. Each phase cycles GREEN -> YELLOW -> ALL_RED. Green times are per-phase runtime inputs, and phases with no vehicle demand are skipped using a rotating pointer. The block sits between the intersection sensor/timing registers and the lamp drivers.

Parameters:
NUM_PHASES, 4, number of signal groups (2..16)
CNT_W, 8, width of the dwell counter and of each green-time field
YELLOW_CYC, 2, yellow dwell; yellow lasts YELLOW_CYC+1 cycles
ALL_RED_CYC, 1, all-red clearance dwell; lasts ALL_RED_CYC+1 cycles
FLASH_CYC, 3, flash half-period; each half lasts FLASH_CYC+1 cycles (used only with FLASH_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
green_time  in  NUM_PHASES*CNT_W  per-phase green dwell; field i is bits [i*CNT_W +: CNT_W]
demand  in  NUM_PHASES  per-phase vehicle request, level-sensitive
light  out  NUM_PHASES*3  per-phase lamp: 3'b001 green, 3'b010 yellow, 3'b100 red, 3'b000 dark
phase_idx  out  $clog2(NUM_PHASES)  phase currently served
state_o  out  2  0 ALL_RED, 1 GREEN, 2 YELLOW, 3 FLASH
count  out  CNT_W  dwell counter
phase_start  out  1  one-cycle pulse in the first cycle of each GREEN
flash  in  1  flash-mode request (present only with FLASH_EN)

Behaviour:
- One clock (clk); reset asynchronous, active-high (rst). All state resets immediately on rst.
- Reset values: state ALL_RED, phase_idx 0, next-pointer ptr 0, count 0, phase_start 0, all light fields 3'b100.
- Dwell rule:
  - Each state has a limit L. If count < L, count increments. Otherwise count goes to 0 and the state advances.
  - A state therefore lasts L+1 cycles.
- Limits per state:
  - GREEN: L = the green_time field of the served phase. It is latched into an internal register on entry, so input changes mid-green have no effect.
  - YELLOW: L = YELLOW_CYC.
  - ALL_RED: L = ALL_RED_CYC.
- Transitions:
  - GREEN -> YELLOW.
  - YELLOW -> ALL_RED, and ptr <= (phase_idx+1) mod NUM_PHASES.
  - ALL_RED -> GREEN, with phase_idx chosen as described below.
- Phase selection:
  - Done on the last ALL_RED cycle. demand is sampled in that cycle.
  - Select the first i in ptr, ptr+1, ... (mod NUM_PHASES) with demand[i]=1.
  - If demand is all zero, select ptr itself (fixed rotation).
- green_time = 0 gives a one-cycle green.
- phase_start is registered and high exactly in the first GREEN cycle.
- Light decode is a combinational function of the registered state and phase_idx, with zero latency relative to state_o:
  - Served phase: GREEN -> 001, YELLOW -> 010, ALL_RED -> 100.
  - All other phases: 100.
- Non-power-of-2 NUM_PHASES: the ptr and phase_idx wrap from NUM_PHASES-1 to 0. Illegal values are never produced.
- Unreachable state encoding returns to ALL_RED with count 0.

Optional Feature:
Macro TRAFFIC_FLASH_EN.
- Defined:
  - The flash port exists. flash=1 forces FLASH on the next edge from any state, and count is cleared.
  - In FLASH, every light field alternates 3'b010 / 3'b000. Each half lasts FLASH_CYC+1 cycles, starting with 010.
  - flash=0 -> ALL_RED with count 0. ptr and phase_idx are unchanged.
  - phase_start stays 0 throughout FLASH.
- Undefined: the flash port is absent, the FLASH encoding is unreachable, and behaviour is as above.

Decomposition:
- Package traffic_pkg:
  - State encoding constants (ST_ALL_RED, ST_GREEN, ST_YELLOW, ST_FLASH).
  - Lamp constants (LAMP_GREEN=3'b001, LAMP_YELLOW=3'b010, LAMP_RED=3'b100, LAMP_DARK=3'b000).
- Sub-module traffic_rr_select: combinational rotating find-first. Inputs demand and ptr; outputs the selected index.

Test Plan:
- NUM_PHASES=4, CNT_W=4, YELLOW_CYC=2, ALL_RED_CYC=1, all green_time=3, demand=4'b1111, release rst:
  - ALL_RED 2 cycles, then phase 0 GREEN 4 / YELLOW 3 / ALL_RED 2 cycles.
  - Then phase 1 green, with phase_start pulsing once per green.
- demand=4'b1000:
  - After reset clearance, phase 3 is served with light[11:9]=001 and all other fields 100.
  - This repeats for phase 3 only.
- demand=0: phases served in order 0,1,2,3,0 with fixed rotation.
- green_time for phase 1 = 0, demand=4'b0010: phase 1 green lasts exactly 1 cycle, then yellow.
- rst asserted mid-green of phase 2:
  - Same cycle, all lights 100, phase_idx 0, count 0.
  - After release, 2 ALL_RED cycles, then phase 0 GREEN.
- TRAFFIC_FLASH_EN, FLASH_CYC=3, flash=1 during phase 1 green:
  - Next cycle all fields 010 for 4 cycles, then 000 for 4 cycles, repeating.
  - flash=0 -> ALL_RED, and the next phase served follows the pointer state saved before flash.
